cfs_rx_ctrl: RTL and testbench

- Receive-side controller of the aligner, upstream of the RX FIFO and the register block.
- Accepts MD transfers from the RX interface and checks each transfer's offset/size against the bus width.
- Legal transfers are pushed into the RX FIFO. Illegal transfers are dropped and counted.
- Supplies status_cnt_drop and max_drop to the register block and consumes its ctrl_clr pulse.

---
 rtl/cfs_rx_ctrl.sv | 91 +++++++++
 tb/tb_cfs_rx_ctrl.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/cfs_rx_ctrl.sv
// cfs_rx_ctrl: RX-side aligner controller; checks MD transfers, pushes legal ones to the FIFO, counts drops.
// Define CFS_RX_CTRL_DROP_ERR_EN to answer dropped transfers with md_rx_err=1 instead of a silent drop.
module cfs_rx_ctrl #(
   parameter  int ALGN_DATA_WIDTH = 32,
   parameter  int CNT_DROP_WIDTH  = 8,
   localparam int OFFSET_WIDTH    = ALGN_DATA_WIDTH <= 8 ? 1 : $clog2(ALGN_DATA_WIDTH/8),
   localparam int SIZE_WIDTH      = $clog2(ALGN_DATA_WIDTH/8) + 1
) (
   input  logic                       pclk,
   input  logic                       presetn,
   input  logic                       md_rx_valid,
   input  logic [ALGN_DATA_WIDTH-1:0] md_rx_data,
   input  logic [OFFSET_WIDTH-1:0]    md_rx_offset,
   input  logic [SIZE_WIDTH-1:0]      md_rx_size,
   output logic                       md_rx_ready,
   output logic                       md_rx_err,
   output logic                       push_valid,
   output logic [ALGN_DATA_WIDTH-1:0] push_data,
   output logic [OFFSET_WIDTH-1:0]    push_offset,
   output logic [SIZE_WIDTH-1:0]      push_size,
   input  logic                       push_ready,
   input  logic                       ctrl_clr,
   output logic [CNT_DROP_WIDTH-1:0]  status_cnt_drop,
   output logic                       max_drop
);
   localparam logic [31:0] B = 32'(ALGN_DATA_WIDTH/8);
   typedef enum logic [1:0] {IDLE, PUSH, RESP} state_t;
   state_t                     state_q, state_d;
   logic [ALGN_DATA_WIDTH-1:0] data_q, data_d;
   logic [OFFSET_WIDTH-1:0]    off_q, off_d;
   logic [SIZE_WIDTH-1:0]      size_q, size_d;
   logic [CNT_DROP_WIDTH-1:0]  cnt_q, cnt_d;
   logic [31:0]                off_w, size_w;
   logic                       legal, drop;
   assign off_w = 32'(md_rx_offset);
   assign size_w = 32'(md_rx_size);
   // the divisor is forced to 1 when size is 0; that case is already illegal
   assign legal = (size_w != 0) && (off_w + size_w <= B)
                  && ((B + off_w) % ((size_w == 0) ? 32'd1 : size_w) == 0);
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      off_d   = off_q;
      size_d  = size_q;
      drop    = 1'b0;
      case (state_q)
         IDLE: if (md_rx_valid) begin
            data_d  = md_rx_data;
            off_d   = md_rx_offset;
            size_d  = md_rx_size;
            drop    = !legal;
            state_d = legal ? PUSH : RESP;
         end
         PUSH: state_d = push_ready ? RESP : PUSH;
         default: state_d = IDLE;
      endcase
      cnt_d = ctrl_clr ? '0 : (drop && !max_drop) ? cnt_q + CNT_DROP_WIDTH'(1) : cnt_q;
   end
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state_q <= IDLE;
         data_q  <= '0;
         off_q   <= '0;
         size_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         off_q   <= off_d;
         size_q  <= size_d;
         cnt_q   <= cnt_d;
      end
   end
   assign push_valid      = state_q == PUSH;
   assign md_rx_ready     = state_q == RESP;
   assign push_data       = data_q;
   assign push_offset     = off_q;
   assign push_size       = size_q;
   assign status_cnt_drop = cnt_q;
   assign max_drop        = &cnt_q;
`ifdef CFS_RX_CTRL_DROP_ERR_EN
   logic err_q;
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) err_q <= 1'b0;
      else if (state_q == IDLE && md_rx_valid) err_q <= drop;
   end
   assign md_rx_err = md_rx_ready && err_q;
`else
   assign md_rx_err = 1'b0;
`endif
endmodule

// File: tb/tb_cfs_rx_ctrl.sv
// tb_cfs_rx_ctrl: directed self-checking bench for cfs_rx_ctrl (32-bit bus, 8-bit drop counter).
module tb_cfs_rx_ctrl;
`ifdef CFS_RX_CTRL_DROP_ERR_EN
   localparam logic ERR_EN = 1'b1;
`else
   localparam logic ERR_EN = 1'b0;
`endif
   logic        pclk = 1'b0, presetn = 1'b0;
   logic        md_rx_valid = 1'b0, push_ready = 1'b1, ctrl_clr = 1'b0;
   logic [31:0] md_rx_data = '0;
   logic [1:0]  md_rx_offset = '0;
   logic [2:0]  md_rx_size = '0;
   logic        md_rx_ready, md_rx_err, push_valid, max_drop;
   logic [31:0] push_data;
   logic [1:0]  push_offset;
   logic [2:0]  push_size;
   logic [7:0]  status_cnt_drop;
   int          checks = 0, errors = 0;

   cfs_rx_ctrl dut (
      .pclk(pclk), .presetn(presetn),
      .md_rx_valid(md_rx_valid), .md_rx_data(md_rx_data), .md_rx_offset(md_rx_offset),
      .md_rx_size(md_rx_size), .md_rx_ready(md_rx_ready), .md_rx_err(md_rx_err),
      .push_valid(push_valid), .push_data(push_data), .push_offset(push_offset),
      .push_size(push_size), .push_ready(push_ready), .ctrl_clr(ctrl_clr),
      .status_cnt_drop(status_cnt_drop), .max_drop(max_drop)
   );

   always #5 pclk = ~pclk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [31:0] d, input logic [1:0] o, input logic [2:0] s);
      @(negedge pclk);
      md_rx_valid = 1'b1; md_rx_data = d; md_rx_offset = o; md_rx_size = s;
   endtask

   task automatic illegal(input string tag, input logic [1:0] o, input logic [2:0] s,
                          input logic [7:0] cnt);
      drive(32'hDEAD_0000, o, s);
      @(negedge pclk);
      chk({tag, "_ready"}, 32'(md_rx_ready), 32'd1);
      chk({tag, "_err"}, 32'(md_rx_err), 32'(ERR_EN));
      chk({tag, "_nopush"}, 32'(push_valid), 32'd0);
      chk({tag, "_cnt"}, 32'(status_cnt_drop), 32'(cnt));
      md_rx_valid = 1'b0;
      @(negedge pclk);
      chk({tag, "_ready_gone"}, 32'(md_rx_ready), 32'd0);
      chk({tag, "_nopush2"}, 32'(push_valid), 32'd0);
   endtask

   initial begin
      repeat (2) @(negedge pclk);
      chk("rst_push_valid", 32'(push_valid), 32'd0);
      chk("rst_ready", 32'(md_rx_ready), 32'd0);
      chk("rst_err", 32'(md_rx_err), 32'd0);
      chk("rst_cnt", 32'(status_cnt_drop), 32'd0);
      chk("rst_max", 32'(max_drop), 32'd0);
      chk("rst_data", push_data, 32'd0);
      presetn = 1'b1;

      drive(32'hAABB_CCDD, 2'd0, 3'd4);
      @(negedge pclk);
      chk("leg_push_valid", 32'(push_valid), 32'd1);
      chk("leg_data", push_data, 32'hAABB_CCDD);
      chk("leg_off", 32'(push_offset), 32'd0);
      chk("leg_size", 32'(push_size), 32'd4);
      chk("leg_early_ready", 32'(md_rx_ready), 32'd0);
      @(negedge pclk);
      chk("leg_ready", 32'(md_rx_ready), 32'd1);
      chk("leg_err", 32'(md_rx_err), 32'd0);
      chk("leg_push_done", 32'(push_valid), 32'd0);
      chk("leg_cnt", 32'(status_cnt_drop), 32'd0);
      md_rx_valid = 1'b0;
      @(negedge pclk);
      chk("leg_ready_gone", 32'(md_rx_ready), 32'd0);

      illegal("ill_size0", 2'd0, 3'd0, 8'd1);
      illegal("ill_o1s2", 2'd1, 3'd2, 8'd2);
      illegal("ill_o3s2", 2'd3, 3'd2, 8'd3);
      illegal("ill_size3", 2'd0, 3'd3, 8'd4);

      push_ready = 1'b0;
      drive(32'h1122_3344, 2'd2, 3'd2);
      for (int i = 0; i < 6; i++) begin
         @(negedge pclk);
         chk("stall_valid", 32'(push_valid), 32'd1);
         chk("stall_data", push_data, 32'h1122_3344);
         chk("stall_off", 32'(push_offset), 32'd2);
         chk("stall_size", 32'(push_size), 32'd2);
         chk("stall_noready", 32'(md_rx_ready), 32'd0);
         md_rx_data = 32'hFFFF_0000 + 32'(i);
         md_rx_size = 3'd0;
         if (i == 5) push_ready = 1'b1;
      end
      @(negedge pclk);
      chk("stall_ready", 32'(md_rx_ready), 32'd1);
      chk("stall_err", 32'(md_rx_err), 32'd0);
      chk("stall_push_done", 32'(push_valid), 32'd0);
      chk("stall_cnt", 32'(status_cnt_drop), 32'd4);
      md_rx_valid = 1'b0;

      for (int i = 0; i < 260; i++) begin
         drive(32'h0, 2'd1, 3'd4);
         @(negedge pclk);
         md_rx_valid = 1'b0;
         @(negedge pclk);
      end
      chk("sat_cnt", 32'(status_cnt_drop), 32'd255);
      chk("sat_max", 32'(max_drop), 32'd1);
      ctrl_clr = 1'b1;
      @(negedge pclk);
      ctrl_clr = 1'b0;
      chk("clr_cnt", 32'(status_cnt_drop), 32'd0);
      chk("clr_max", 32'(max_drop), 32'd0);

      illegal("pre_coinc", 2'd0, 3'd7, 8'd1);
      drive(32'h0, 2'd2, 3'd4);
      ctrl_clr = 1'b1;
      @(negedge pclk);
      ctrl_clr = 1'b0;
      chk("coinc_cnt", 32'(status_cnt_drop), 32'd0);
      chk("coinc_ready", 32'(md_rx_ready), 32'd1);
      md_rx_valid = 1'b0;
      @(negedge pclk);

      push_ready = 1'b0;
      drive(32'h5555_AAAA, 2'd0, 3'd2);
      @(negedge pclk);
      md_rx_valid = 1'b0;
      chk("mid_push_valid", 32'(push_valid), 32'd1);
      presetn = 1'b0;
      #1;
      chk("mid_rst_push", 32'(push_valid), 32'd0);
      chk("mid_rst_ready", 32'(md_rx_ready), 32'd0);
      chk("mid_rst_data", push_data, 32'd0);
      chk("mid_rst_size", 32'(push_size), 32'd0);
      @(negedge pclk);
      presetn = 1'b1;
      push_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge pclk);
         chk("post_rst_push", 32'(push_valid), 32'd0);
         chk("post_rst_ready", 32'(md_rx_ready), 32'd0);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
